// File: rtl/arith_pkg.sv
// Shared definitions for the iterative arithmetic unit: default operand width,
// control-state encoding and the iteration-counter sizing rule.
package arith_pkg;

  localparam int MUL_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  // One extra bit so the counter can hold WIDTH itself without wrapping.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/signed_multiplier_if.sv
// Start/ready handshake and operand/result bus of the signed multiplier.
interface signed_multiplier_if
  import arith_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);

  logic                      start;
  logic signed [WIDTH-1:0]   A;
  logic signed [WIDTH-1:0]   B;
  logic signed [2*WIDTH-1:0] product;
  logic                      ready;

  modport master (
    output start,
    output A,
    output B,
    input  product,
    input  ready
  );

  modport slave (
    input  start,
    input  A,
    input  B,
    output product,
    output ready
  );

endinterface

// File: rtl/twos_abs.sv
// Splits an N-bit two's-complement value into sign and unsigned magnitude;
// the most negative value maps to 2^(N-1), which still fits in N unsigned bits.
module twos_abs #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] x,
  output logic        [N-1:0] mag,
  output logic                sign
);

  logic [N-1:0] x_u;

  assign x_u  = x;
  assign sign = x_u[N-1];
  assign mag  = sign ? (~x_u + 1'b1) : x_u;

endmodule

// File: rtl/signed_multiplier.sv
// Sequential sign-magnitude shift-add multiplier: one partial product per BUSY
// cycle, WIDTH cycles per operation, sign applied combinationally at the output.
module signed_multiplier
  import arith_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  signed_multiplier_if.slave bus
);

  localparam int              CNT_W = cnt_width(WIDTH);
  localparam int              PW    = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag,
                                               input logic          neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  mul_state_e       state_q;
  mul_state_e       state_d;
  logic [PW-1:0]    acc_q;
  logic [WIDTH-1:0] mcand_q;
  logic             neg_q;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             a_sign;
  logic             b_sign;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             ready_w;

  twos_abs #(.N(WIDTH)) u_abs_a (
    .x    (bus.A),
    .mag  (a_mag),
    .sign (a_sign)
  );

  twos_abs #(.N(WIDTH)) u_abs_b (
    .x    (bus.B),
    .mag  (b_mag),
    .sign (b_sign)
  );

  // Upper half accumulates; the carry lands in bit WIDTH and is shifted in.
  assign addend = acc_q[0] ? mcand_q : '0;
  assign sum    = {1'b0, acc_q[PW-1:WIDTH]} + {1'b0, addend};

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = BUSY;
      BUSY: begin
        if (bus.start)            state_d = BUSY;
        else if (count_q == LAST) state_d = DONE;
      end
      DONE:    if (bus.start) state_d = BUSY;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // start wins in every state: reload aborts any operation in flight.
      if (bus.start) begin
        mcand_q <= a_mag;
        acc_q   <= {{WIDTH{1'b0}}, b_mag};
        neg_q   <= a_sign ^ b_sign;
        count_q <= '0;
      end else if (state_q == BUSY) begin
        acc_q   <= {sum, acc_q[WIDTH-1:1]};
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign ready_w     = (state_q == DONE);
  assign bus.ready   = ready_w;
  assign bus.product = ready_w ? $signed(apply_sign(acc_q, neg_q)) : '0;

endmodule

// File: doc/signed_multiplier.md
# signed_multiplier

Sequential shift-add signed multiplier computing A×B for the arithmetic unit; it is the inverse operation of the team's iterative signed divider. It has the same start/ready handshake and the same sign-magnitude datapath style. Operands are converted to magnitudes, multiplied unsigned over WIDTH iterations, and sign-corrected at the output.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH.

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  load operands and begin; accepted in every state
- A  input  WIDTH  signed multiplicand, two's complement
- B  input  WIDTH  signed multiplier, two's complement
- product  output  2*WIDTH  signed A×B; valid only while ready=1, else 0
- ready  output  1  result valid, held until next start

## Operation
- States: IDLE, BUSY, DONE.
  - Reset forces IDLE, ready=0, product=0.
  - IDLE→BUSY on start.
  - BUSY→DONE after iteration WIDTH-1.
  - DONE→BUSY on start.
  - BUSY with start → reload and restart (abort current operation).
- Load on start edge:
  - mcand ← |A|.
  - acc[2W-1:0] ← {W'0, |B|}.
  - neg ← A[W-1]^B[W-1] (latched; later input changes ignored).
  - count ← 0.
- Magnitude: x[W-1] ? ~x+1 : x.
  - |−2^(W-1)| = 2^(W-1), still representable as unsigned W bits.
- Iteration, one per BUSY cycle:
  - sum[W:0] = acc[2W-1:W] + (acc[0] ? mcand : 0), with carry kept in bit W.
  - acc ← {sum, acc[W-1:1]}, a logical right shift by 1 with carry into the MSB.
  - count ← count+1.
- Counter is $clog2(WIDTH)+1 bits and never wraps during an operation.
- product = ready ? (neg ? ~acc+1 : acc) : 0.
  - Negated zero yields 0.
  - Full 2W-bit result; no overflow is possible.

## Timing
- Start sampled at edge t0. Iterations run at edges t0+1 … t0+WIDTH.
- ready rises after edge t0+WIDTH, i.e. latency WIDTH cycles (32 by default).
- In DONE, ready and product are stable indefinitely.
- A start edge clears ready at that same edge. ready is never high in the cycle after a start is sampled.
- Single-cycle start pulse suffices. Holding start high keeps reloading; ready stays 0.
- Asynchronous rst_n assertion at any time:
  - immediately ready=0, product=0, state IDLE;
  - any in-flight operation is discarded.
- After rst_n deassertion, the first start is honoured at the first rising edge.
- No back-pressure: the consumer samples product while ready=1.

## Structure
- Package `arith_pkg`:
  - MUL_WIDTH=32 default constant;
  - state enum {IDLE, BUSY, DONE};
  - counter width function or constant.
- Sub-module `twos_abs` (parameter N): outputs magnitude and sign of an N-bit two's-complement input.
  - Instantiated for A and B.
  - Final negation is inline (~acc+1).
- Single always block for the FSM plus datapath registers with asynchronous reset; output logic is combinational.

## Test plan
- Reset: rst_n=0 for 2 cycles, then 1 → ready=0 and product=64'h0 before any start; the first start is accepted.
- Basic signs, with ready asserting exactly 32 cycles after each start:
  - A=7, B=−3 → product=64'hFFFF_FFFF_FFFF_FFEB;
  - A=−7, B=−3 → 64'h15;
  - A=0, B=−5 → 64'h0.
- Extremes:
  - A=B=32'h8000_0000 → 64'h4000_0000_0000_0000;
  - A=32'h8000_0000, B=1 → 64'hFFFF_FFFF_8000_0000;
  - A=B=32'hFFFF_FFFF → 64'h1;
  - A=B=32'h7FFF_FFFF → 64'h3FFF_FFFF_0000_0001.
- Restart mid-operation: start A=5, B=6; at cycle 10 start A=−2, B=9 → ready stays 0 until 32 cycles after the second start, then product=−18 (64'hFFFF_FFFF_FFFF_FFEE).
- Reset mid-operation, operand hold, and random signed pairs:
  - Assert rst_n=0 at cycle 15 of a busy operation → ready=0 and product=0 asynchronously (same timestep); a new start after release gives the correct result.
  - Change A/B while BUSY → result reflects the operands sampled at start.
  - 1000 random signed pairs checked against a $signed 64-bit reference model.
